fsic_is_rx_fifo: RTL and testbench
==================================

Name: fsic_is_rx_fifo

Overview:
- Receive-side buffer directly downstream of the IO serdes in the FSIC axis path.
- Captures every beat the serdes emits on is_as_* and presents it to the local AXI-Stream switch as a first-word-fall-through master stream.
- The serdes RX path has no backpressure, so this block generates the local as_is_tready flow-control bit from FIFO fill level. The serdes forwards that bit to the remote side, which stops sending before the FIFO overflows.

Parameters:
pDATA_WIDTH, 32, tdata width; tstrb/tkeep width is pDATA_WIDTH/8
pDEPTH, 8, FIFO entries (>=2, need not be a power of two)
pTHRESHOLD, 4, as_is_tready deasserts when free entries <= pTHRESHOLD (headroom for in-flight serdes beats); must be < pDEPTH

Ports:
axis_clk  in  1  core clock; sole clock
axis_rst_n  in  1  synchronous active-low reset
is_as_tdata  in  pDATA_WIDTH  beat data from serdes
is_as_tstrb  in  pDATA_WIDTH/8  byte strobes
is_as_tkeep  in  pDATA_WIDTH/8  byte keeps
is_as_tlast  in  1  last beat of packet
is_as_tid  in  2  stream id
is_as_tuser  in  2  user bits
is_as_tvalid  in  1  beat present; must be accepted (no ready)
as_is_tready  out  1  local-can-accept flag, returned to serdes TX for the remote side
m_tdata  out  pDATA_WIDTH  head-entry data
m_tstrb  out  pDATA_WIDTH/8  head-entry strobes
m_tkeep  out  pDATA_WIDTH/8  head-entry keeps
m_tlast  out  1  head-entry last
m_tid  out  2  head-entry id
m_tuser  out  2  head-entry user
m_tvalid  out  1  FIFO non-empty
m_tready  in  1  downstream accepts head
fifo_level  out  $clog2(pDEPTH+1)  current entry count
overflow  out  1  sticky: beat dropped because FIFO was full
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (axis_rst_n=0 at a posedge axis_clk): wptr=rptr=0, fifo_level=0, overflow=0, as_is_tready=0, m_tvalid=0.
  - Reset mid-operation flushes all stored entries.
  - Reset is synchronous only: no effect between edges.
- Entry layout: {tlast, tid, tuser, tkeep, tstrb, tdata}, stored and returned bit-exact.
- Push: when is_as_tvalid=1 and (fifo_level<pDEPTH or pop this cycle).
  - Write to mem[wptr].
  - wptr increments, wrapping from pDEPTH-1 to 0.
- Pop: when m_tvalid=1 and m_tready=1.
  - rptr increments with the same wrap rule.
- Simultaneous push and pop: allowed when full and when empty-with-push.
  - Full: the pop frees a slot; level stays pDEPTH and the beat is stored.
  - Empty: m_tvalid=0, so no pop occurs; level becomes 1.
- Level update: level_next = level + push - pop. Never exceeds pDEPTH, never goes below 0.
- Overflow: is_as_tvalid=1 while level==pDEPTH and no pop.
  - The beat is discarded and overflow<=1.
  - Pointers and level are unchanged.
- overflow_clr=1 clears overflow next cycle; if an overflow event occurs in the same cycle, set wins.
- Output path is first-word-fall-through:
  - m_tvalid = (fifo_level != 0).
  - m_* = mem[rptr], combinational from registered state.
  - Zero-cycle latency from a stored entry to m_tvalid; data appears the cycle after the push edge.
  - m_* payload is don't-care while m_tvalid=0.
- m_* hold stable while m_tvalid=1 and m_tready=0.
- as_is_tready is a registered output: as_is_tready <= ((pDEPTH - level_next) > pTHRESHOLD).
  - It updates the same edge as the level, so it reflects the post-update level.
  - First cycle after reset release: 0.
  - From the second edge onward, with an empty FIFO: 1.
- No combinational path from any input to as_is_tready.
- fifo_level is the registered count.

Test Plan:
- Reset then idle -> as_is_tready 0 during reset, 1 one edge after release; m_tvalid=0; fifo_level=0; overflow=0.
- Push 4 beats (tdata 0x11111111..0x44444444, tlast on beat 4), m_tready=0 -> fifo_level=4; as_is_tready drops to 0 at the edge storing beat 4 (free=4<=4). Raising m_tready pops beats in order with exact tstrb/tkeep/tid/tuser/tlast; as_is_tready returns to 1 after the first pop.
- Fill to 8 with m_tready=0, then a 9th beat 0xDEADBEEF -> beat dropped, overflow=1, level stays 8; draining returns the original 8 beats only. overflow_clr=1 clears overflow.
- Full FIFO with m_tready=1 and is_as_tvalid=1 on the same cycle -> level stays 8, no overflow, new beat appears after the remaining 7.
- Continuous push+pop streaming of 100 beats with m_tready=1 -> level stays ≤1, order preserved across pointer wrap, as_is_tready constant 1.
- Assert axis_rst_n=0 with 5 entries stored -> next edge level=0, m_tvalid=0, as_is_tready=0, overflow=0; old data never reappears after refill.

Source files
------------

// File: rtl/fsic_is_rx_fifo_if.sv
// AXI-Stream bundle used on both sides of the FSIC serdes RX FIFO.
//   master modport: drives tdata/tstrb/tkeep/tlast/tid/tuser/tvalid, samples tready
//   slave  modport: samples the payload and tvalid, drives tready
interface fsic_is_rx_fifo_if #(
   parameter int unsigned pDATA_WIDTH = 32
);
   logic [pDATA_WIDTH-1:0]   tdata;
   logic [pDATA_WIDTH/8-1:0] tstrb;
   logic [pDATA_WIDTH/8-1:0] tkeep;
   logic                     tlast;
   logic [1:0]               tid;
   logic [1:0]               tuser;
   logic                     tvalid;
   logic                     tready;

   modport master (
      output tdata, tstrb, tkeep, tlast, tid, tuser, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tkeep, tlast, tid, tuser, tvalid,
      output tready
   );
endinterface

// File: rtl/fsic_is_rx_fifo.sv
// Receive-side FIFO behind the IO serdes in the FSIC axis path.
// Every serdes beat is captured (the serdes cannot be stalled) and replayed to the
// local AXI-Stream switch as a first-word-fall-through stream. The flow-control bit
// returned to the remote side is derived from the fill level.
// Ports:
//   axis_clk, axis_rst_n : clock, synchronous active-low reset
//   is_as (slave)        : beats from serdes; is_as.tready is the registered
//                          local-can-accept flag returned to the remote side
//   m (master)           : FWFT output stream, payload = head entry
//   fifo_level           : registered entry count
//   overflow             : sticky, a beat was dropped on a full FIFO
//   overflow_clr         : clears overflow (a same-cycle drop wins)
module fsic_is_rx_fifo #(
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned pDEPTH      = 8,
   parameter int unsigned pTHRESHOLD  = 4
) (
   input  logic                         axis_clk,
   input  logic                         axis_rst_n,
   fsic_is_rx_fifo_if.slave             is_as,
   fsic_is_rx_fifo_if.master            m,
   output logic [$clog2(pDEPTH+1)-1:0]  fifo_level,
   output logic                         overflow,
   input  logic                         overflow_clr
);
   localparam int unsigned SW = pDATA_WIDTH / 8;
   localparam int unsigned EW = pDATA_WIDTH + 2 * SW + 5;
   localparam int unsigned LW = $clog2(pDEPTH + 1);
   localparam int unsigned PW = $clog2(pDEPTH);

   typedef logic [EW-1:0] entry_t;

   entry_t          mem_q [pDEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic            tready_q, tready_d;
   logic            push, pop, drop;
   entry_t          wr_entry;
   entry_t          rd_entry;

   assign wr_entry = {is_as.tlast, is_as.tid, is_as.tuser, is_as.tkeep, is_as.tstrb,
                      is_as.tdata};

   always_comb begin
      pop  = (level_q != '0) && m.tready;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push = is_as.tvalid && ((level_q != LW'(pDEPTH)) || pop);
      drop = is_as.tvalid && !push;

      wptr_d = wptr_q;
      if (push) begin
         wptr_d = (wptr_q == PW'(pDEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end

      rptr_d = rptr_q;
      if (pop) begin
         rptr_d = (rptr_q == PW'(pDEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Set wins over clear.
      overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

      // Headroom kept free for beats already in flight from the remote side.
      tready_d = (pDEPTH - 32'(level_d)) > pTHRESHOLD;
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         tready_q   <= tready_d;
      end
   end

   // Storage needs no reset; validity is tracked by level_q.
   always_ff @(posedge axis_clk) begin
      if (axis_rst_n && push) begin
         mem_q[wptr_q] <= wr_entry;
      end
   end

   always_comb begin
      rd_entry = mem_q[rptr_q];
   end

   assign {m.tlast, m.tid, m.tuser, m.tkeep, m.tstrb, m.tdata} = rd_entry;
   assign m.tvalid     = (level_q != '0);
   assign is_as.tready = tready_q;
   assign fifo_level   = level_q;
   assign overflow     = overflow_q;
endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
module tb_fsic_is_rx_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int THR   = 4;
   localparam int EW    = DW + 2 * (DW / 8) + 5;

   typedef logic [EW-1:0] ent_t;

   logic clk;
   logic drv_rst;
   logic drv_valid;
   logic drv_ready;
   logic drv_clr;
   ent_t drv_ent;
   ent_t m_ent;
   logic [3:0] fifo_level;
   logic overflow;

   ent_t sb[$];
   logic model_ovf;
   logic model_rdy;
   int   vectors;
   int   miscompares;

   fsic_is_rx_fifo_if #(.pDATA_WIDTH(DW)) s_if ();
   fsic_is_rx_fifo_if #(.pDATA_WIDTH(DW)) m_if ();

   assign {s_if.tlast, s_if.tid, s_if.tuser, s_if.tkeep, s_if.tstrb, s_if.tdata} = drv_ent;
   assign s_if.tvalid = drv_valid;
   assign m_if.tready = drv_ready;
   assign m_ent = {m_if.tlast, m_if.tid, m_if.tuser, m_if.tkeep, m_if.tstrb, m_if.tdata};

   fsic_is_rx_fifo #(
      .pDATA_WIDTH(DW),
      .pDEPTH     (DEPTH),
      .pTHRESHOLD (THR)
   ) dut (
      .axis_clk    (clk),
      .axis_rst_n  (drv_rst),
      .is_as       (s_if),
      .m           (m_if),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .overflow_clr(drv_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic ent_t mk(input logic [31:0] data, input logic last);
      logic [3:0] strb = 4'($urandom);
      logic [3:0] keep = 4'($urandom);
      logic [1:0] id   = 2'($urandom);
      logic [1:0] user = 2'($urandom);
      return {last, id, user, keep, strb, data};
   endfunction

   // One clock edge; the scoreboard follows the intended FIFO behaviour from the
   // bench's own drive values, then returns at the next falling edge.
   task automatic step();
      bit pop_m, push_m, drop_m;
      @(posedge clk);
      pop_m  = (sb.size() != 0) && drv_ready;
      push_m = drv_valid && ((sb.size() < DEPTH) || pop_m);
      drop_m = drv_valid && !push_m;
      if (!drv_rst) begin
         sb.delete();
         model_ovf = 1'b0;
         model_rdy = 1'b0;
      end else begin
         if (pop_m) void'(sb.pop_front());
         if (push_m) sb.push_back(drv_ent);
         model_ovf = drop_m ? 1'b1 : (drv_clr ? 1'b0 : model_ovf);
         model_rdy = (DEPTH - sb.size()) > THR;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drv_rst = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0; drv_clr = 1'b0; drv_ent = '0;
      step();
      step();
      vectors += 4;
      if (s_if.tready !== 1'b0) begin miscompares++;
         $display("FAIL reset_tready got %b want 0", s_if.tready); end
      if (m_if.tvalid !== 1'b0) begin miscompares++;
         $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
      if (fifo_level !== 4'd0) begin miscompares++;
         $display("FAIL reset_level got %0d want 0", fifo_level); end
      if (overflow !== 1'b0) begin miscompares++;
         $display("FAIL reset_overflow got %b want 0", overflow); end
      drv_rst = 1'b1;
      #1;
      vectors++;
      if (s_if.tready !== 1'b0) begin miscompares++;
         $display("FAIL release_tready_first got %b want 0", s_if.tready); end
      step();
      vectors++;
      if (s_if.tready !== 1'b1) begin miscompares++;
         $display("FAIL release_tready_second got %b want 1", s_if.tready); end
   endtask

   task automatic test_push_pop();
      bit first = 1'b1;
      drv_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv_valid = 1'b1;
         drv_ent = mk(32'h1111_1111 * (i + 1), i == 3);
         step();
         vectors += 2;
         if (fifo_level !== 4'(i + 1)) begin miscompares++;
            $display("FAIL pp_level got %0d want %0d", fifo_level, i + 1); end
         if (s_if.tready !== (i < 3)) begin miscompares++;
            $display("FAIL pp_tready got %b want %b", s_if.tready, (i < 3)); end
      end
      drv_valid = 1'b0;
      step();  // hold with m_tready low; head must not move
      drv_ready = 1'b1;
      for (int n = 0; n < 10 && sb.size() != 0; n++) begin
         vectors++;
         if (m_if.tvalid !== 1'b1 || m_ent !== sb[0]) begin miscompares++;
            $display("FAIL pp_pop got %b/%h want 1/%h", m_if.tvalid, m_ent, sb[0]); end
         step();
         if (first) begin
            first = 1'b0;
            vectors++;
            if (s_if.tready !== 1'b1) begin miscompares++;
               $display("FAIL pp_tready_after_pop got %b want 1", s_if.tready); end
         end
      end
      vectors++;
      if (sb.size() != 0 || m_if.tvalid !== 1'b0) begin miscompares++;
         $display("FAIL pp_drain got tvalid %b left %0d want 0", m_if.tvalid, sb.size()); end
   endtask

   task automatic test_overflow();
      drv_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drv_valid = 1'b1;
         drv_ent = mk($urandom, 1'($urandom));
         step();
      end
      vectors++;
      if (fifo_level !== 4'd8) begin miscompares++;
         $display("FAIL ovf_full_level got %0d want 8", fifo_level); end
      drv_ent = mk(32'hDEAD_BEEF, 1'b1);
      step();
      vectors += 3;
      if (overflow !== 1'b1) begin miscompares++;
         $display("FAIL ovf_set got %b want 1", overflow); end
      if (fifo_level !== 4'd8) begin miscompares++;
         $display("FAIL ovf_level got %0d want 8", fifo_level); end
      if (m_ent !== sb[0]) begin miscompares++;
         $display("FAIL ovf_head got %h want %h", m_ent, sb[0]); end
      drv_clr = 1'b1;  // drop in the same cycle: set wins
      step();
      vectors++;
      if (overflow !== model_ovf) begin miscompares++;
         $display("FAIL ovf_set_wins got %b want %b", overflow, model_ovf); end
      drv_valid = 1'b0;
      step();
      drv_clr = 1'b0;
      vectors++;
      if (overflow !== 1'b0) begin miscompares++;
         $display("FAIL ovf_clr got %b want 0", overflow); end
   endtask

   task automatic test_full_simul();
      drv_ready = 1'b1;
      drv_valid = 1'b1;
      drv_ent = mk(32'hA5A5_0001, 1'b1);
      vectors++;
      if (m_ent !== sb[0]) begin miscompares++;
         $display("FAIL fs_head got %h want %h", m_ent, sb[0]); end
      step();
      vectors += 2;
      if (fifo_level !== 4'd8) begin miscompares++;
         $display("FAIL fs_level got %0d want 8", fifo_level); end
      if (overflow !== 1'b0) begin miscompares++;
         $display("FAIL fs_overflow got %b want 0", overflow); end
      drv_valid = 1'b0;
      for (int n = 0; n < 12 && sb.size() != 0; n++) begin
         vectors++;
         if (m_if.tvalid !== 1'b1 || m_ent !== sb[0]) begin miscompares++;
            $display("FAIL fs_pop got %b/%h want 1/%h", m_if.tvalid, m_ent, sb[0]); end
         step();
      end
      vectors++;
      if (fifo_level !== 4'd0 || sb.size() != 0) begin miscompares++;
         $display("FAIL fs_drain got level %0d want 0", fifo_level); end
   endtask

   task automatic test_stream();
      drv_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drv_valid = 1'b1;
         drv_ent = mk($urandom, 1'($urandom));
         if (sb.size() != 0) begin
            vectors++;
            if (m_if.tvalid !== 1'b1 || m_ent !== sb[0]) begin miscompares++;
               $display("FAIL st_pop %0d got %b/%h want 1/%h", i, m_if.tvalid, m_ent, sb[0]);
            end
         end
         step();
         vectors += 2;
         if (fifo_level > 4'd1 || fifo_level !== 4'(sb.size())) begin miscompares++;
            $display("FAIL st_level got %0d want %0d", fifo_level, sb.size()); end
         if (s_if.tready !== 1'b1) begin miscompares++;
            $display("FAIL st_tready got %b want 1", s_if.tready); end
      end
      drv_valid = 1'b0;
      for (int n = 0; n < 4 && sb.size() != 0; n++) begin
         vectors++;
         if (m_ent !== sb[0]) begin miscompares++;
            $display("FAIL st_tail got %h want %h", m_ent, sb[0]); end
         step();
      end
   endtask

   task automatic test_reset_flush();
      drv_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drv_valid = 1'b1;
         drv_ent = mk(32'hC0DE_0000 + i, 1'b0);
         step();
      end
      drv_valid = 1'b0;
      drv_rst = 1'b0;
      #1;
      vectors++;
      if (fifo_level !== 4'd5) begin miscompares++;
         $display("FAIL rf_between_edges got %0d want 5", fifo_level); end
      step();
      vectors += 4;
      if (fifo_level !== 4'd0) begin miscompares++;
         $display("FAIL rf_level got %0d want 0", fifo_level); end
      if (m_if.tvalid !== 1'b0) begin miscompares++;
         $display("FAIL rf_tvalid got %b want 0", m_if.tvalid); end
      if (s_if.tready !== 1'b0) begin miscompares++;
         $display("FAIL rf_tready got %b want 0", s_if.tready); end
      if (overflow !== 1'b0) begin miscompares++;
         $display("FAIL rf_overflow got %b want 0", overflow); end
      drv_rst = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         drv_valid = 1'b1;
         drv_ent = mk(32'h7700_0000 + i, i == 1);
         step();
      end
      drv_valid = 1'b0;
      drv_ready = 1'b1;
      for (int n = 0; n < 6 && sb.size() != 0; n++) begin
         vectors++;
         if (m_if.tvalid !== 1'b1 || m_ent !== sb[0]) begin miscompares++;
            $display("FAIL rf_refill got %b/%h want 1/%h", m_if.tvalid, m_ent, sb[0]); end
         step();
      end
      vectors++;
      if (m_if.tvalid !== 1'b0 || fifo_level !== 4'd0) begin miscompares++;
         $display("FAIL rf_stale got tvalid %b level %0d want 0/0", m_if.tvalid, fifo_level);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      model_ovf = 1'b0;
      model_rdy = 1'b0;
      test_reset();
      test_push_pop();
      test_overflow();
      test_full_simul();
      test_stream();
      test_reset_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
